// File: rtl/teclado_pkg.sv
// teclado_pkg: shared FSM state type, key-code table and row helpers for the teclado keypad scanner.
// Contents: state_t, IDLE_ROWS, KEY_MAP, one_low(), low_index(), row_mask(), key_code().
package teclado_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

    localparam logic [3:0] IDLE_ROWS = 4'b1111;

    // Entry {row, col} (both zero-based) gives the code; * = E, # = F.
    localparam logic [0:15][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] rows);
        logic [3:0] low;
        low = ~rows;
        return low != 4'd0 && (low & (low - 4'd1)) == 4'd0;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [3:0] row_mask(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/teclado_debounce.sv
// teclado_debounce: consecutive-match counter shared by press and release qualification.
// Ports: clk, reset (sync, active-high), clear (restart count), match (condition sampled this cycle),
//        stable (match has held for DEBOUNCE_CYCLES consecutive cycles, this one included).
module teclado_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic match,
    output logic stable
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    // cnt holds the number of consecutive earlier matching cycles, saturating at LAST.
    logic [7:0] cnt;

    assign stable = match && cnt == LAST;

    always_ff @(posedge clk) begin
        if (reset || clear || !match) cnt <= '0;
        else if (cnt != LAST) cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/teclado.sv
// teclado: 4x4 matrix keypad scanner with press/release debounce and a one-cycle key strobe.
// Ports: clk, reset (sync, active-high), linhas[4:1] (rows, active-low), colunas[4:1] (one-hot-low
//        column drive), numero[4:1] (last accepted key code), insere (one-cycle new-key strobe).
// Macro TECLADO_DEBOUNCE_EN: when defined, presses and releases are debounced over DEBOUNCE_CYCLES;
//        otherwise a detected key is emitted at once and release ends on the first idle sample.
module teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:1] linhas,
    output logic [4:1] colunas,
    output logic [4:1] numero,
    output logic       insere
);

`ifdef TECLADO_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    state_t     state;
    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] scan_cnt;
    logic       scan_done;
    logic       hit;
    logic       same;
    logic       idle;
    logic       match;
    logic       clear;
    logic       stable;

    assign scan_done = scan_cnt == 4'(SCAN_CYCLES - 1);
    assign hit       = scan_done && one_low(linhas);
    assign same      = linhas == row_mask(row);
    assign idle      = linhas == IDLE_ROWS;
    assign colunas   = ~(4'b0001 << col);
    assign match     = state == DEBOUNCE ? same : state == RELEASE && idle;
    assign clear     = state == SCAN || state == EMIT;

    teclado_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .match (match),
        .stable(stable)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SCAN;
            col      <= '0;
            row      <= '0;
            scan_cnt <= '0;
            numero   <= '0;
            insere   <= 1'b0;
        end else begin
            insere <= 1'b0;
            case (state)
                SCAN: begin
                    scan_cnt <= scan_done ? 4'd0 : scan_cnt + 4'd1;
                    if (hit) begin
                        row <= low_index(linhas);
                        if (DEBOUNCE_EN) begin
                            state <= DEBOUNCE;
                        end else begin
                            state  <= EMIT;
                            insere <= 1'b1;
                            numero <= key_code(low_index(linhas), col);
                        end
                    end else if (scan_done) begin
                        col <= col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!same) begin
                        state <= SCAN;
                        col   <= col + 2'd1;
                    end else if (stable) begin
                        state  <= EMIT;
                        insere <= 1'b1;
                        numero <= key_code(row, col);
                    end
                end
                EMIT: state <= RELEASE;
                RELEASE: begin
                    // Column stays frozen until the key is let go.
                    if (DEBOUNCE_EN ? stable : idle) begin
                        state <= SCAN;
                        col   <= col + 2'd1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
